pwm_peripheral: RTL and testbench
=================================

// Module: pwm_peripheral
// PURPOSE
// - Consumes the 9 configuration registers written by the SPI register block; drives 8 outputs out[7:0].
// - Contains 2 PWM generators (gen0, gen1), each with 2 compare channels (ch0, ch1).
// - Each output is routed to off, static high, or one of the 4 PWM sources.
// - Sits between the SPI register file and the chip output pads; purely clk-domain.
// PARAMETERS
// - CNT_W  8  PWM period counter / duty width; period = 2^CNT_W-1 = 255 ticks
// - DIV_W  4  per-generator prescaler divider field width
// PORTS
// - clk                   in   1  system clock
// - rst_n                 in   1  asynchronous, active-low reset
// - en_out                in   8  per-output enable; 0 -> output forced low
// - en_pwm_out            in   8  per-output mode; 0 -> static high (if enabled), 1 -> PWM
// - out_3_0_sel           in   8  2-bit source select per output: [1:0]=out0 .. [7:6]=out3
// - out_7_4_sel           in   8  2-bit source select per output: [1:0]=out4 .. [7:6]=out7
// - gen0_ch0_duty         in   8  duty for gen0 ch0
// - gen0_ch1_duty         in   8  duty for gen0 ch1
// - gen1_ch0_duty         in   8  duty for gen1 ch0
// - gen1_ch1_duty         in   8  duty for gen1 ch1
// - freq_div              in   8  [3:0]=gen0 divider, [7:4]=gen1 divider
// - out                   out  8  registered output bits
// - period_start          out  2  1-clk pulse per generator when its counter restarts at 0
// BEHAVIOUR
// - Reset: out=0, period_start=0, all prescalers=0, period counters=0, all shadow duty/div regs=0.
// - Prescaler (per gen k): 4-bit pre_cnt counts clk; tick when pre_cnt==div_sh_k, then pre_cnt<=0.
//   Tick rate = clk/(div_sh_k+1); div 0 -> tick every clk, div 15 -> every 16 clks.
// - Period counter: on tick, cnt<=cnt+1; when cnt==254 and tick -> cnt<=0 (period = 255 ticks).
// - Shadowing: at the wrap (cnt==254 & tick) duty_sh_k_c<=duty input, div_sh_k<=div nibble;
//   period_start[k] pulses in the cycle cnt becomes 0. Register writes mid-period never glitch.
// - Immediately after reset, shadows are 0 -> every PWM source low until first wrap loads them.
// - Compare: pwm_k_c = (cnt_k < duty_sh_k_c). duty 0 -> always low; duty 255 -> always high (cnt<=254).
// - Source select encoding: sel[1]=generator, sel[0]=channel (00=g0c0,01=g0c1,10=g1c0,11=g1c1).
// - Output i next value: !en_out[i] -> 0; else !en_pwm_out[i] -> 1; else pwm[sel_i].
// - Latency: en_out / en_pwm_out / sel changes reach out one clk later (registered, no shadowing).
// - Duty/div changes take effect at the start of the next period only.
// - Simultaneous input change on the wrap cycle: the value present on that cycle is captured.
// - Both generators free-run independently; no enable gating; counters never saturate, only wrap.
// - Reset asserted mid-period: all state returns to reset values asynchronously; out=0 at once.
// STRUCTURE
// - Package pwm_pkg: CNT_MAX=8'd254, SEL_G0C0/G0C1/G1C0/G1C1 2-bit localparams, DIV_W, CNT_W.
// - Sub-module pwm_gen: prescaler + period counter + 2 shadowed compare channels;
//   ports clk, rst_n, div, duty0, duty1 -> pwm[1:0], period_start. Instantiated twice.
// - Top: 8 identical 4:1 muxes + enable/mode gating into one 8-bit output register.
// TESTING
// - Reset: hold rst_n=0, drive all inputs 0xFF -> out==0, period_start==0; release -> out==0 until gen wrap.
// - Static: en_out=0xFF, en_pwm_out=0x00 -> out==0xFF one clk later; en_out=0x0F -> out==0x0F next clk.
// - Duty: div=0, g0c0 duty=64, out0 sel=00, en_pwm_out[0]=1 -> after first wrap out0 high 64 of every 255 clks.
// - Divider: freq_div=0x31, g1c1 duty=128 on out7 -> g0 period 510 clks, g1 period 1020 clks, out7 high 512.
// - Extremes: duty=0 -> out never high over 3 periods; duty=255 -> out never low after first wrap.
// - Shadowing: change g0c1 duty 32->200 at cnt=100 -> current period stays 32 high, next period 200 high.

Source files
------------

// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared constants and small helpers for the PWM peripheral:
//   CNT_W / DIV_W   counter and prescaler widths
//   CNT_MAX         last count value of a period (period = CNT_MAX+1 ticks)
//   SEL_*           2-bit output source encodings ({generator, channel})
// -----------------------------------------------------------------------------
package pwm_pkg;

   localparam int CNT_W   = 8;
   localparam int DIV_W   = 4;
   localparam int NUM_OUT = 8;

   localparam logic [CNT_W-1:0] CNT_MAX = 8'd254;

   localparam logic [1:0] SEL_G0C0 = 2'b00;
   localparam logic [1:0] SEL_G0C1 = 2'b01;
   localparam logic [1:0] SEL_G1C0 = 2'b10;
   localparam logic [1:0] SEL_G1C1 = 2'b11;

   // Picks one of the four PWM sources; pwm is packed as {g1c1, g1c0, g0c1, g0c0}.
   function automatic logic pick_source(input logic [3:0] pwm, input logic [1:0] sel);
      case (sel)
         SEL_G0C0: return pwm[0];
         SEL_G0C1: return pwm[1];
         SEL_G1C0: return pwm[2];
         default:  return pwm[3];
      endcase
   endfunction

   // Enable has priority over mode: disabled -> low, static mode -> high.
   function automatic logic output_bit(input logic en, input logic pwm_mode, input logic src);
      if (!en)       return 1'b0;
      if (!pwm_mode) return 1'b1;
      return src;
   endfunction

endpackage

// File: rtl/pwm_gen.sv
// -----------------------------------------------------------------------------
// pwm_gen
// One PWM generator: prescaler, 255-tick period counter and two compare
// channels. Divider and duties are shadowed and only reloaded when the
// period wraps, so register writes mid-period never glitch the outputs.
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   div             prescaler divider (tick every div+1 clocks)
//   duty0, duty1    channel duty values (high while count < duty)
//   pwm[1:0]        compare outputs {ch1, ch0}
//   period_start    1-clk pulse in the cycle the counter restarts at 0
// -----------------------------------------------------------------------------
module pwm_gen
   import pwm_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [DIV_W-1:0] div,
   input  logic [CNT_W-1:0] duty0,
   input  logic [CNT_W-1:0] duty1,
   output logic [1:0]       pwm,
   output logic             period_start
);

   logic [DIV_W-1:0] r_pre_cnt;
   logic [DIV_W-1:0] r_div_sh;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_duty0_sh;
   logic [CNT_W-1:0] r_duty1_sh;
   logic             r_period_start;

   logic w_tick;
   logic w_wrap;

   // Compare against the shadowed divider so a new divider cannot cut a
   // prescaler interval short mid-period.
   assign w_tick = (r_pre_cnt == r_div_sh);
   assign w_wrap = w_tick && (r_cnt == CNT_MAX);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pre_cnt      <= '0;
         r_div_sh       <= '0;
         r_cnt          <= '0;
         r_duty0_sh     <= '0;
         r_duty1_sh     <= '0;
         r_period_start <= 1'b0;
      end else begin
         r_period_start <= w_wrap;

         if (w_tick) begin
            r_pre_cnt <= '0;
            r_cnt     <= w_wrap ? '0 : r_cnt + 1'b1;
         end else begin
            r_pre_cnt <= r_pre_cnt + 1'b1;
         end

         // Shadows capture whatever is on the inputs in the wrap cycle.
         if (w_wrap) begin
            r_div_sh   <= div;
            r_duty0_sh <= duty0;
            r_duty1_sh <= duty1;
         end
      end
   end

   // Count never exceeds 254, so duty 255 keeps the channel permanently high.
   assign pwm          = {(r_cnt < r_duty1_sh), (r_cnt < r_duty0_sh)};
   assign period_start = r_period_start;

endmodule

// File: rtl/pwm_peripheral.sv
// -----------------------------------------------------------------------------
// pwm_peripheral
// Two free-running PWM generators (2 channels each) routed to 8 registered
// outputs. Each output is off, static high, or one of the 4 PWM sources.
// Ports:
//   clk, rst_n         system clock, asynchronous active-low reset
//   en_out[7:0]        per-output enable (0 forces the output low)
//   en_pwm_out[7:0]    per-output mode (0 static high, 1 PWM)
//   out_3_0_sel        2-bit source selects for out0..out3 (out0 in [1:0])
//   out_7_4_sel        2-bit source selects for out4..out7 (out4 in [1:0])
//   genX_chY_duty      duty per generator/channel
//   freq_div           [3:0] gen0 divider, [7:4] gen1 divider
//   out[7:0]           registered outputs
//   period_start[1:0]  per-generator period restart pulse
// -----------------------------------------------------------------------------
module pwm_peripheral
   import pwm_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_OUT-1:0] en_out,
   input  logic [NUM_OUT-1:0] en_pwm_out,
   input  logic [7:0]         out_3_0_sel,
   input  logic [7:0]         out_7_4_sel,
   input  logic [CNT_W-1:0]   gen0_ch0_duty,
   input  logic [CNT_W-1:0]   gen0_ch1_duty,
   input  logic [CNT_W-1:0]   gen1_ch0_duty,
   input  logic [CNT_W-1:0]   gen1_ch1_duty,
   input  logic [7:0]         freq_div,
   output logic [NUM_OUT-1:0] out,
   output logic [1:0]         period_start
);

   logic [1:0]           w_pwm_g0;
   logic [1:0]           w_pwm_g1;
   logic [3:0]           w_pwm;
   logic [15:0]          w_sel_all;
   logic [NUM_OUT-1:0]   w_out_next;
   logic [NUM_OUT-1:0]   r_out;

   pwm_gen u_gen0 (
      .clk          (clk),
      .rst_n        (rst_n),
      .div          (freq_div[DIV_W-1:0]),
      .duty0        (gen0_ch0_duty),
      .duty1        (gen0_ch1_duty),
      .pwm          (w_pwm_g0),
      .period_start (period_start[0])
   );

   pwm_gen u_gen1 (
      .clk          (clk),
      .rst_n        (rst_n),
      .div          (freq_div[2*DIV_W-1:DIV_W]),
      .duty0        (gen1_ch0_duty),
      .duty1        (gen1_ch1_duty),
      .pwm          (w_pwm_g1),
      .period_start (period_start[1])
   );

   // Index into w_pwm equals the select code {generator, channel}.
   assign w_pwm     = {w_pwm_g1, w_pwm_g0};
   assign w_sel_all = {out_7_4_sel, out_3_0_sel};

   // NOTE: the default assignment first means every path assigns
   // w_out_next, so no latch can be inferred.
   always_comb begin
      w_out_next = '0;
      for (int i = 0; i < NUM_OUT; i++) begin
         w_out_next[i] = output_bit(en_out[i], en_pwm_out[i],
                                    pick_source(w_pwm, w_sel_all[2*i +: 2]));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_out <= '0;
      else        r_out <= w_out_next;
   end

   assign out = r_out;

endmodule

// File: tb/tb_pwm_peripheral.sv
// -----------------------------------------------------------------------------
// tb_pwm_peripheral
// Reference model: each generator is a position within a period of
// 255*(div+1) clocks; a channel is high while floor(pos/(div+1)) < duty.
// Divider and duties are reloaded from the inputs on the last clock of a
// period. Expected register values are queued every clock and a monitor
// compares them against the DUT on the falling edge.
// -----------------------------------------------------------------------------
module tb_pwm_peripheral;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] en_out, en_pwm_out, out_3_0_sel, out_7_4_sel;
   logic [7:0] gen0_ch0_duty, gen0_ch1_duty, gen1_ch0_duty, gen1_ch1_duty;
   logic [7:0] freq_div;
   logic [7:0] out;
   logic [1:0] period_start;

   int n_vec = 0;
   int n_err = 0;

   typedef struct packed {
      logic [7:0] o;
      logic [1:0] ps;
   } sb_t;
   sb_t sb_q[$];

   // Model state
   int m_pos  [2] = '{0, 0};
   int m_div  [2] = '{0, 0};
   int m_duty [2][2] = '{'{0, 0}, '{0, 0}};

   pwm_peripheral dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .en_out        (en_out),
      .en_pwm_out    (en_pwm_out),
      .out_3_0_sel   (out_3_0_sel),
      .out_7_4_sel   (out_7_4_sel),
      .gen0_ch0_duty (gen0_ch0_duty),
      .gen0_ch1_duty (gen0_ch1_duty),
      .gen1_ch0_duty (gen1_ch0_duty),
      .gen1_ch1_duty (gen1_ch1_duty),
      .freq_div      (freq_div),
      .out           (out),
      .period_start  (period_start)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one step per rising edge, expectation pushed to the queue.
   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            m_pos[k] = 0; m_div[k] = 0; m_duty[k][0] = 0; m_duty[k][1] = 0;
         end
         sb_q.delete();
      end else begin
         logic [3:0]  src;
         logic [15:0] sels;
         sb_t         e;
         int          len;
         sels = {out_7_4_sel, out_3_0_sel};
         for (int k = 0; k < 2; k++)
            for (int c = 0; c < 2; c++)
               src[2*k+c] = ((m_pos[k] / (m_div[k] + 1)) < m_duty[k][c]);
         for (int i = 0; i < 8; i++)
            e.o[i] = !en_out[i] ? 1'b0 : (!en_pwm_out[i] ? 1'b1 : src[sels[2*i +: 2]]);
         for (int k = 0; k < 2; k++) begin
            len = 255 * (m_div[k] + 1);
            if (m_pos[k] == len - 1) begin
               e.ps[k]      = 1'b1;
               m_pos[k]     = 0;
               m_div[k]     = (k == 0) ? int'(freq_div[3:0]) : int'(freq_div[7:4]);
               m_duty[k][0] = (k == 0) ? int'(gen0_ch0_duty) : int'(gen1_ch0_duty);
               m_duty[k][1] = (k == 0) ? int'(gen0_ch1_duty) : int'(gen1_ch1_duty);
            end else begin
               e.ps[k]  = 1'b0;
               m_pos[k] = m_pos[k] + 1;
            end
         end
         sb_q.push_back(e);
      end
   end

   // Monitor: the registered outputs are valid every clock out of reset.
   initial forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && sb_q.size() > 0) begin
         sb_t e;
         e = sb_q.pop_front();
         check("sb_out", 32'(out), 32'(e.o));
         check("sb_period_start", 32'(period_start), 32'(e.ps));
      end
   end

   task automatic wait_ps(input int k, input int budget);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (period_start[k] !== 1'b1 && n < budget);
      if (period_start[k] !== 1'b1) begin
         n_vec++;
         n_err++;
         $display("FAIL wait_ps%0d: no period_start within %0d clks", k, budget);
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic set_all(input logic [7:0] v);
      en_out = v; en_pwm_out = v; out_3_0_sel = v; out_7_4_sel = v;
      gen0_ch0_duty = v; gen0_ch1_duty = v; gen1_ch0_duty = v; gen1_ch1_duty = v;
      freq_div = v;
   endtask

   initial begin
      int cnt_a, cnt_b, g0_per, g1_per;

      // Reset with every input at 0xFF
      rst_n = 1'b0;
      set_all(8'hFF);
      repeat (3) @(negedge clk);
      check("rst_out", 32'(out), 32'h0);
      check("rst_period_start", 32'(period_start), 32'h0);
      rst_n = 1'b1;
      repeat (200) @(negedge clk);
      check("pre_wrap_out", 32'(out), 32'h0);
      wait_ps(0, 100);
      repeat (3) @(negedge clk);
      check("post_wrap_out", 32'(out), 32'hFF);

      // Asynchronous reset mid-cycle
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_out", 32'(out), 32'h0);
      check("async_rst_ps", 32'(period_start), 32'h0);

      // Static outputs, one-clock latency
      @(negedge clk);
      set_all(8'h00);
      en_out = 8'hFF;
      rst_n  = 1'b1;
      @(negedge clk);
      check("static_ff", 32'(out), 32'hFF);
      en_out = 8'h0F;
      @(negedge clk);
      check("static_0f", 32'(out), 32'h0F);

      // Duty 64 on out0
      apply_reset();
      set_all(8'h00);
      gen0_ch0_duty = 8'd64; en_out = 8'h01; en_pwm_out = 8'h01;
      rst_n = 1'b1;
      wait_ps(0, 300);
      cnt_a = 0;
      repeat (255) begin @(negedge clk); cnt_a += int'(out[0]); end
      check("duty64_high", 32'(cnt_a), 32'd64);

      // Dividers: gen0 div 1, gen1 div 3, g1c1 duty 128 on out7
      apply_reset();
      set_all(8'h00);
      freq_div = 8'h31; gen1_ch1_duty = 8'd128; out_7_4_sel = 8'hC0;
      en_out = 8'h80; en_pwm_out = 8'h80;
      rst_n = 1'b1;
      wait_ps(1, 300);
      cnt_a = 0; g0_per = 0; g1_per = 0;
      for (int i = 1; i <= 1100; i++) begin
         @(negedge clk);
         cnt_a += int'(out[7]);
         if (period_start[0] && g0_per == 0) g0_per = i;
         if (period_start[1]) begin g1_per = i; break; end
      end
      check("g0_period", 32'(g0_per), 32'd510);
      check("g1_period", 32'(g1_per), 32'd1020);
      check("g1c1_high", 32'(cnt_a), 32'd512);

      // Extremes: duty 0 on out0, duty 255 on out1
      apply_reset();
      set_all(8'h00);
      gen0_ch1_duty = 8'd255; out_3_0_sel = 8'h04;
      en_out = 8'h03; en_pwm_out = 8'h03;
      rst_n = 1'b1;
      wait_ps(0, 300);
      @(negedge clk);
      cnt_a = 0; cnt_b = 0;
      repeat (765) begin
         @(negedge clk);
         cnt_a += int'(out[0]);
         cnt_b += int'(!out[1]);
      end
      check("duty0_highs", 32'(cnt_a), 32'd0);
      check("duty255_lows", 32'(cnt_b), 32'd0);

      // Shadowing: g0c1 on out2, duty 32 -> 200 mid-period
      apply_reset();
      set_all(8'h00);
      gen0_ch1_duty = 8'd32; out_3_0_sel = 8'h10;
      en_out = 8'h04; en_pwm_out = 8'h04;
      rst_n = 1'b1;
      wait_ps(0, 300);
      cnt_a = 0;
      for (int i = 0; i < 255; i++) begin
         @(negedge clk);
         cnt_a += int'(out[2]);
         if (i == 99) gen0_ch1_duty = 8'd200;
      end
      check("shadow_cur_period", 32'(cnt_a), 32'd32);
      cnt_a = 0;
      repeat (255) begin @(negedge clk); cnt_a += int'(out[2]); end
      check("shadow_next_period", 32'(cnt_a), 32'd200);

      // Randomized configuration, checked by the scoreboard
      for (int r = 0; r < 12; r++) begin
         @(negedge clk);
         en_out        = 8'($urandom);
         en_pwm_out    = 8'($urandom);
         out_3_0_sel   = 8'($urandom);
         out_7_4_sel   = 8'($urandom);
         gen0_ch0_duty = 8'($urandom);
         gen0_ch1_duty = (r % 4 == 0) ? 8'd255 : 8'($urandom);
         gen1_ch0_duty = (r % 4 == 1) ? 8'd0 : 8'($urandom);
         gen1_ch1_duty = 8'($urandom);
         freq_div      = 8'($urandom) & 8'h33;
         repeat ($urandom_range(60, 400)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
